// File: rtl/data_sram_bridge_pkg.sv
// rtl/data_sram_bridge_pkg.sv - shared defines for the data-SRAM bridge
package data_sram_bridge_pkg;

    localparam int   StallBus    = 6;
    localparam int   StallMemBit = 3;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

    localparam int BusAddrW = 32;
    localparam int BusDataW = 32;
    localparam int BusStrbW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dsram_timeout_cnt.sv
// rtl/dsram_timeout_cnt.sv - saturating ack-wait counter with sticky timeout flag
module dsram_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic err
);

    localparam int            CW     = (LIMIT > 255) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};
    localparam logic [CW-1:0] Limit  = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Flag raises on the cycle that completes LIMIT waits and never clears until reset.
        if (inc && cnt_d == Limit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - EX/MEM data-SRAM responder over a req/ack word bus
// Optional macro DSRAM_POSTED_STORE_EN: stores retire without stalling or a RESP visit.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [StallBus-1:0] stall,
    input  logic                data_sram_en,
    input  logic [BusStrbW-1:0] data_sram_wen,
    input  logic [BusAddrW-1:0] data_sram_addr,
    input  logic [BusDataW-1:0] data_sram_wdata,
    output logic [BusDataW-1:0] data_sram_rdata,
    output logic                stallreq_for_mem,
    output logic                bus_req,
    output logic [BusStrbW-1:0] bus_wstrb,
    output logic [BusAddrW-1:0] bus_addr,
    output logic [BusDataW-1:0] bus_wdata,
    input  logic                bus_ack,
    input  logic [BusDataW-1:0] bus_rdata,
    output logic                bus_err
);

`ifdef DSRAM_POSTED_STORE_EN
    localparam logic PostedStores = 1'b1;
`else
    localparam logic PostedStores = 1'b0;
`endif

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic [BusStrbW-1:0] bus_wstrb_q, bus_wstrb_d;
    logic [BusAddrW-1:0] bus_addr_q, bus_addr_d;
    logic [BusDataW-1:0] bus_wdata_q, bus_wdata_d;
    logic [BusDataW-1:0] resp_buf_q, resp_buf_d;
    logic [BusDataW-1:0] rdata_q, rdata_d;
    logic                posted_q, posted_d;
    logic                stallreq_c;
    logic                to_clr, to_inc;
    logic                unused_inputs;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        resp_buf_d  = resp_buf_q;
        rdata_d     = rdata_q;
        posted_d    = posted_q;
        stallreq_c  = 1'b0;
        to_clr      = 1'b0;
        to_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stallreq_c = data_sram_en && !(PostedStores && data_sram_wen != '0);
                if (data_sram_en) begin
                    bus_req_d   = 1'b1;
                    bus_wstrb_d = data_sram_wen;
                    bus_addr_d  = {data_sram_addr[BusAddrW-1:2], 2'b00};
                    bus_wdata_d = data_sram_wdata;
                    posted_d    = PostedStores && (data_sram_wen != '0);
                    to_clr      = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // A posted store only holds back whatever EX presents behind it.
                stallreq_c = posted_q ? data_sram_en : 1'b1;
                if (bus_ack) begin
                    resp_buf_d = (bus_wstrb_q == '0) ? bus_rdata : '0;
                    bus_req_d  = 1'b0;
                    state_d    = posted_q ? IDLE : RESP;
                end else begin
                    to_inc = 1'b1;
                end
            end
            RESP: begin
                if (stall[StallMemBit] == NoStop) begin
                    rdata_d = resp_buf_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_wstrb_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            resp_buf_q  <= '0;
            rdata_q     <= '0;
            posted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            resp_buf_q  <= resp_buf_d;
            rdata_q     <= rdata_d;
            posted_q    <= posted_d;
        end
    end

    dsram_timeout_cnt #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timeout (
        .clk(clk),
        .rst(rst),
        .clr(to_clr),
        .inc(to_inc),
        .err(bus_err)
    );

    // Gated so the stall request is also 0 while reset is held.
    assign stallreq_for_mem = rst && stallreq_c;
    assign data_sram_rdata  = rdata_q;
    assign bus_req          = bus_req_q;
    assign bus_wstrb        = bus_wstrb_q;
    assign bus_addr         = bus_addr_q;
    assign bus_wdata        = bus_wdata_q;

    assign unused_inputs = ^{stall[StallBus-1:StallMemBit+1], stall[StallMemBit-1:0],
                             data_sram_addr[1:0]};

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - directed and randomized checks of data_sram_bridge against a transaction model
module tb_data_sram_bridge;
    import data_sram_bridge_pkg::*;

`ifdef DSRAM_POSTED_STORE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [StallBus-1:0] stall;
    logic                data_sram_en;
    logic [3:0]          data_sram_wen;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;
    logic [31:0]         data_sram_rdata;
    logic                stallreq_for_mem;
    logic                bus_req;
    logic [3:0]          bus_wstrb;
    logic [31:0]         bus_addr;
    logic [31:0]         bus_wdata;
    logic                bus_ack;
    logic [31:0]         bus_rdata;
    logic                bus_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata;
    bit          err_m;

    data_sram_bridge #(
        .ACK_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq_for_mem(stallreq_for_mem),
        .bus_req(bus_req),
        .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One EX access: ack arrives in BUSY cycle ack_cycle, MEM held for hold cycles after completion.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int ack_cycle, input int hold);
        bit                  posted;
        int                  stalls;
        logic [StallBus-1:0] s;
        posted = POSTED && (wen != 4'd0);
        stalls = 0;
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        stall           = '0;
        bus_ack         = 1'b0;
        #1;
        if (stallreq_for_mem) stalls++;
        chk("idle_bus_req", bus_req, 0);
        @(negedge clk);
        if (posted) data_sram_en = 1'b0;
        for (int k = 1; k <= ack_cycle; k++) begin
            chk("busy_bus_req", bus_req, 1);
            chk("busy_bus_addr", bus_addr, {addr[31:2], 2'b00});
            chk("busy_bus_wstrb", bus_wstrb, wen);
            chk("busy_bus_wdata", bus_wdata, wdata);
            chk("busy_bus_err", bus_err, err_m || (k - 1 >= 255));
            chk("busy_rdata_hold", data_sram_rdata, exp_rdata);
            stall     = StallBus'($urandom);
            bus_ack   = (k == ack_cycle);
            bus_rdata = (k == ack_cycle) ? rd : $urandom;
            #1;
            if (stallreq_for_mem) stalls++;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        if (ack_cycle - 1 >= 255) err_m = 1'b1;
        chk("stall_cycles", stalls, posted ? 0 : 1 + ack_cycle);
        if (!posted) begin
            for (int h = 0; h <= hold; h++) begin
                s = StallBus'($urandom);
                s[StallMemBit] = (h < hold) ? Stop : NoStop;
                stall     = s;
                bus_ack   = (h < hold);
                bus_rdata = $urandom;
                #1;
                chk("resp_stallreq", stallreq_for_mem, 0);
                chk("resp_bus_req", bus_req, 0);
                chk("resp_rdata_old", data_sram_rdata, exp_rdata);
                @(negedge clk);
            end
            bus_ack   = 1'b0;
            exp_rdata = (wen == 4'd0) ? rd : 32'd0;
        end
        data_sram_en = 1'b0;
        stall        = '0;
        #1;
        chk("done_rdata", data_sram_rdata, exp_rdata);
        chk("done_bus_req", bus_req, 0);
        chk("done_stallreq", stallreq_for_mem, 0);
        chk("done_bus_err", bus_err, err_m);
    endtask

    initial begin
        logic [3:0] w;
        rst             = 1'b0;
        stall           = '0;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'hFFFF_FFFF;
        data_sram_wdata = 32'hFFFF_FFFF;
        bus_ack         = 1'b0;
        bus_rdata       = 32'hFFFF_FFFF;
        exp_rdata       = 32'd0;
        err_m           = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata", data_sram_rdata, 0);
        chk("rst_stallreq", stallreq_for_mem, 0);
        chk("rst_bus_err", bus_err, 0);
        rst          = 1'b1;
        data_sram_en = 1'b0;
        @(negedge clk);

        access(4'b0000, 32'h0000_1004, $urandom, 32'hDEAD_BEEF, 1, 0);
        access(4'b0011, 32'h0000_2003, 32'h1234_5678, $urandom, 4, 0);
        access(4'b0000, 32'h0000_3008, $urandom, 32'hCAFE_F00D, 2, 3);
        access(4'b0000, 32'h0000_4000, $urandom, 32'h0000_0011, 1, 0);
        access(4'b0000, 32'h0000_4004, $urandom, 32'h0000_0022, 1, 0);

        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("stray_ack_bus_req", bus_req, 0);
        chk("stray_ack_rdata", data_sram_rdata, exp_rdata);

        access(4'b0000, 32'h0000_5000, $urandom, 32'h5A5A_A5A5, 258, 1);
        access(4'b0000, 32'h0000_5004, $urandom, 32'h0BAD_CAFE, 2, 0);

        for (int i = 0; i < 12; i++) begin
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            access(w, $urandom, $urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, 3));
        end

        data_sram_en   = 1'b1;
        data_sram_wen  = 4'd0;
        data_sram_addr = 32'h0000_6000;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_bus_req", bus_req, 0);
        chk("arst_stallreq", stallreq_for_mem, 0);
        chk("arst_rdata", data_sram_rdata, 0);
        chk("arst_bus_err", bus_err, 0);
        exp_rdata = 32'd0;
        err_m     = 1'b0;
        @(negedge clk);
        rst          = 1'b1;
        data_sram_en = 1'b0;
        bus_ack      = 1'b1;
        bus_rdata    = 32'h7777_7777;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_bus_req", bus_req, 0);
        chk("post_rst_rdata", data_sram_rdata, 0);
        access(4'b0000, 32'h0000_7000, $urandom, 32'h600D_D00D, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Responder end of the data-SRAM interface that the EX stage drives and the MEM stage reads. The block accepts a load or store from EX and completes it over a variable-latency word bus with a req/ack handshake. It stalls the pipeline through `ctrl` until the access is done. Read data changes only on the clock edge where the EX→MEM register advances, so MEM always sees the word for the instruction it holds.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: BUSY cycles without `bus_ack` before the error flag sets.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in `StallBus`: pipeline stall vector; bit 3 = EX→MEM hold (`Stop` = 1).
- `data_sram_en` in 1: access request from EX, held while stalled.
- `data_sram_wen` in 4: byte write enables; 0 means load.
- `data_sram_addr` in 32: word address; bits 1:0 are ignored.
- `data_sram_wdata` in 32: store data.
- `data_sram_rdata` out 32: load data consumed by MEM.
- `stallreq_for_mem` out 1: stall request to `ctrl`.
- `bus_req` out 1: backend request, registered.
- `bus_wstrb` out 4: byte strobes; 0 = read.
- `bus_addr` out 32: word-aligned address.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: backend completion, one cycle.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_err` out 1: sticky timeout flag.

## Operation
- FSM states IDLE, BUSY, RESP. Reset state is IDLE. All registers reset to 0, so every output is 0 during reset.
- IDLE:
  - If `data_sram_en`=1: latch addr (bits 1:0 forced to 0), wen, wdata into `bus_*`; set `bus_req`; go to BUSY.
  - `stallreq_for_mem` = `data_sram_en`, combinational.
- BUSY:
  - `bus_req`=1 and `stallreq_for_mem`=1.
  - Inputs from EX are ignored; latched values stay on the bus.
  - On `bus_ack`: capture `bus_rdata` into `resp_buf` (0 for stores), clear `bus_req`, go to RESP.
- RESP:
  - `stallreq_for_mem`=0.
  - On an edge with `stall[3]`=NoStop: `rdata_r` ← `resp_buf`, go to IDLE.
  - Otherwise hold the state. The request EX is still presenting is never reissued.
- `data_sram_rdata` = `rdata_r`. It changes only on the RESP→IDLE edge and is stable across any MEM/WB stall.
- Timeout: a counter clears on entering BUSY and counts BUSY cycles. Reaching `ACK_TIMEOUT` sets `bus_err`, which stays set until reset. The FSM keeps waiting.
- `bus_ack` outside BUSY is ignored.

## Timing
- Minimum load latency, with ack in the first BUSY cycle:
  - Cycle N: request in IDLE.
  - N+1: BUSY with ack.
  - N+2: RESP.
  - N+3: MEM holds the instruction and `data_sram_rdata` is valid.
  - This costs 2 stall cycles.
- Each extra ack-wait cycle adds one stall cycle.
- Back-to-back requests: at least one IDLE cycle between completions. A new request is seen in IDLE on the cycle after RESP.
- Asynchronous reset mid-BUSY drops the transaction: `bus_req` falls immediately and no response is produced.

## Configuration
- `DSRAM_POSTED_STORE_EN` defined:
  - A store in IDLE does not assert `stallreq_for_mem`.
  - The FSM goes to BUSY without visiting RESP afterwards; on ack it returns to IDLE and `rdata_r` is unchanged.
  - Any request arriving while a posted store is in BUSY stalls until the ack, then is handled from IDLE.
- Undefined: stores follow the same IDLE→BUSY→RESP path as loads.

## Structure
- Put the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the bus request width in the shared defines header, next to `StallBus`/`Stop`.
- One sub-module, `dsram_timeout_cnt`: an 8+ bit saturating counter producing the sticky error.

## Test plan
- Load 0x0000_1004, ack in the first BUSY cycle with rdata 0xDEAD_BEEF → `bus_addr`=0x1004, stall exactly 2 cycles, `data_sram_rdata`=0xDEAD_BEEF on the cycle after RESP.
- Store wen=4'b0011, wdata 0x1234_5678, addr 0x2003, ack after 4 cycles → `bus_wstrb`=0011, `bus_addr`=0x2000, stall 5 cycles, `rdata_r` ← 0.
- Load completes while `stall[3]`=Stop for 3 extra cycles → FSM stays in RESP, no second `bus_req`, `data_sram_rdata` keeps its old value until the release edge.
- Two consecutive loads returning 0x11 then 0x22 → two separate `bus_req` pulses; MEM sees 0x11 then 0x22 each aligned to its own instruction.
- No ack for 255 cycles → `bus_err`=1 on cycle 255; a later ack completes normally and `bus_err` stays 1.
- Deassert `rst` mid-BUSY → `bus_req`, `stallreq_for_mem`, `data_sram_rdata` = 0 asynchronously; with `DSRAM_POSTED_STORE_EN`, a store produces zero stall cycles.
